// File: rtl/id_filter_reg_ctrl.sv
// Write controller for the ID-filter register bank: round-robin host/loader arbitration and bank clears.
// Optional host write-protect enabled by defining ID_FILTER_REG_LOCK_EN.
module id_filter_reg_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned AW       = 4
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                HostReq,
    input  logic [AW-1:0]       HostAddr,
    input  logic [WIDTH-1:0]    HostData,
    output logic                HostAck,
    input  logic                LdReq,
    input  logic [AW-1:0]       LdAddr,
    input  logic [WIDTH-1:0]    LdData,
    output logic                LdAck,
    output logic                AddrErr,
    input  logic                ClrReq,
    output logic                ClrDone,
    output logic                Busy,
    input  logic                Lock,
    output logic [NUM_REGS-1:0] RegWrite,
    output logic [WIDTH-1:0]    RegData,
    output logic                RegSyncReset
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PTR_HOST = 1'b0,
        PTR_LD   = 1'b1
    } ptr_t;

    state_t              r_state, w_state_nxt;
    ptr_t                r_ptr, w_ptr_nxt;
    logic                r_clr_pend, w_clr_pend_nxt;
    logic                r_host_ack, w_host_ack_nxt;
    logic                r_ld_ack, w_ld_ack_nxt;
    logic                r_addr_err, w_addr_err_nxt;
    logic                r_clr_done, w_clr_done_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_sync_rst, w_sync_rst_nxt;
    logic [NUM_REGS-1:0] r_reg_write, w_reg_write_nxt;
    logic [WIDTH-1:0]    r_reg_data, w_reg_data_nxt;

    logic                w_host_elig;
    logic                w_ld_elig;
    logic                w_gnt_any;
    logic                w_gnt_ld;
    logic [AW-1:0]       w_gnt_addr;
    logic [WIDTH-1:0]    w_gnt_data;
    logic                w_addr_ok;
    logic [NUM_REGS-1:0] w_wr_onehot;

    // A requester whose Ack is currently high is masked so it cannot be granted twice
`ifdef ID_FILTER_REG_LOCK_EN
    assign w_host_elig = HostReq & ~r_host_ack & ~Lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = Lock;
    assign w_host_elig   = HostReq & ~r_host_ack;
`endif
    assign w_ld_elig = LdReq & ~r_ld_ack;

    assign w_gnt_any   = w_host_elig | w_ld_elig;
    assign w_gnt_ld    = w_ld_elig & (~w_host_elig | (r_ptr == PTR_LD));
    assign w_gnt_addr  = w_gnt_ld ? LdAddr : HostAddr;
    assign w_gnt_data  = w_gnt_ld ? LdData : HostData;
    assign w_addr_ok   = (32'(w_gnt_addr) < NUM_REGS);
    assign w_wr_onehot = NUM_REGS'(1) << w_gnt_addr;

    // State and registered outputs
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_IDLE;
            r_ptr       <= PTR_HOST;
            r_clr_pend  <= 1'b0;
            r_host_ack  <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_addr_err  <= 1'b0;
            r_clr_done  <= 1'b0;
            r_busy      <= 1'b0;
            r_sync_rst  <= 1'b0;
            r_reg_write <= '0;
            r_reg_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_clr_pend  <= w_clr_pend_nxt;
            r_host_ack  <= w_host_ack_nxt;
            r_ld_ack    <= w_ld_ack_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_clr_done  <= w_clr_done_nxt;
            r_busy      <= w_busy_nxt;
            r_sync_rst  <= w_sync_rst_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_reg_data  <= w_reg_data_nxt;
        end
    end

    // Next state; clears take priority over writes and are only launched from IDLE
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_clr_pend_nxt  = r_clr_pend | ClrReq;
        w_host_ack_nxt  = 1'b0;
        w_ld_ack_nxt    = 1'b0;
        w_addr_err_nxt  = 1'b0;
        w_clr_done_nxt  = 1'b0;
        w_sync_rst_nxt  = 1'b0;
        w_reg_write_nxt = '0;
        w_reg_data_nxt  = r_reg_data;

        case (r_state)
            S_IDLE: begin
                if (r_clr_pend || ClrReq) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_pend_nxt = 1'b0;
                    w_sync_rst_nxt = 1'b1;
                end else if (w_gnt_any) begin
                    w_state_nxt     = S_WRITE;
                    w_host_ack_nxt  = ~w_gnt_ld;
                    w_ld_ack_nxt    = w_gnt_ld;
                    w_addr_err_nxt  = ~w_addr_ok;
                    w_reg_write_nxt = w_addr_ok ? w_wr_onehot : '0;
                    w_reg_data_nxt  = w_gnt_data;
                    w_ptr_nxt       = w_gnt_ld ? PTR_HOST : PTR_LD;
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            S_CLEAR: begin
                w_state_nxt    = S_DONE;
                w_clr_done_nxt = 1'b1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign HostAck      = r_host_ack;
    assign LdAck        = r_ld_ack;
    assign AddrErr      = r_addr_err;
    assign ClrDone      = r_clr_done;
    assign Busy         = r_busy;
    assign RegSyncReset = r_sync_rst;
    assign RegWrite     = r_reg_write;
    assign RegData      = r_reg_data;

endmodule

// File: tb/tb_id_filter_reg_ctrl.sv
// Bench for id_filter_reg_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_id_filter_reg_ctrl;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned AW       = 4;
`ifdef ID_FILTER_REG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                Clk = 1'b0;
    logic                nReset = 1'b1;
    logic                HostReq = 1'b0;
    logic [AW-1:0]       HostAddr = '0;
    logic [WIDTH-1:0]    HostData = '0;
    logic                HostAck;
    logic                LdReq = 1'b0;
    logic [AW-1:0]       LdAddr = '0;
    logic [WIDTH-1:0]    LdData = '0;
    logic                LdAck;
    logic                AddrErr;
    logic                ClrReq = 1'b0;
    logic                ClrDone;
    logic                Busy;
    logic                Lock = 1'b0;
    logic [NUM_REGS-1:0] RegWrite;
    logic [WIDTH-1:0]    RegData;
    logic                RegSyncReset;

    int n_cmp  = 0;
    int n_fail = 0;

    // {HostAck, LdAck, AddrErr, ClrDone, Busy, RegSyncReset}
    logic [5:0] flags;
    assign flags = {HostAck, LdAck, AddrErr, ClrDone, Busy, RegSyncReset};

    id_filter_reg_ctrl #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .AW(AW)) dut (
        .Clk(Clk), .nReset(nReset),
        .HostReq(HostReq), .HostAddr(HostAddr), .HostData(HostData), .HostAck(HostAck),
        .LdReq(LdReq), .LdAddr(LdAddr), .LdData(LdData), .LdAck(LdAck),
        .AddrErr(AddrErr), .ClrReq(ClrReq), .ClrDone(ClrDone), .Busy(Busy),
        .Lock(Lock), .RegWrite(RegWrite), .RegData(RegData), .RegSyncReset(RegSyncReset)
    );

    always #5 Clk = ~Clk;

    // Expected behaviour of one clock cycle
    typedef struct packed {
        logic                hack;
        logic                lack;
        logic                aerr;
        logic                done;
        logic                busy;
        logic                sync;
        logic [NUM_REGS-1:0] wr;
        logic [WIDTH-1:0]    data;
        logic                dchk;
    } exp_t;

    exp_t m_cur;
    exp_t m_q[$];
    bit   m_pend;
    bit   m_ptr_ld;

    task automatic model_reset();
        m_cur    = '0;
        m_q.delete();
        m_pend   = 1'b0;
        m_ptr_ld = 1'b0;
    endtask

    // Called at each rising edge with the inputs that edge sees
    task automatic model_step();
        exp_t e;
        bit   he, le, g_ld;
        int   a;
        if (!nReset) return;
        if (!m_cur.busy) begin
            if (m_pend || ClrReq) begin
                e = '0; e.busy = 1'b1; e.sync = 1'b1; m_q.push_back(e);
                e = '0; e.busy = 1'b1; e.done = 1'b1; m_q.push_back(e);
                m_pend = 1'b0;
            end else begin
                he = HostReq && !m_cur.hack && !(LOCK_EN && Lock);
                le = LdReq && !m_cur.lack;
                if (he || le) begin
                    g_ld     = le && (!he || m_ptr_ld);
                    m_ptr_ld = !g_ld;
                    a        = g_ld ? int'(LdAddr) : int'(HostAddr);
                    e        = '0;
                    e.busy   = 1'b1;
                    e.hack   = !g_ld;
                    e.lack   = g_ld;
                    if (a < int'(NUM_REGS)) begin
                        e.wr[a] = 1'b1;
                        e.data  = g_ld ? LdData : HostData;
                        e.dchk  = 1'b1;
                    end else begin
                        e.aerr = 1'b1;
                    end
                    m_q.push_back(e);
                end
            end
        end else if (ClrReq) begin
            m_pend = 1'b1;
        end
        m_cur = (m_q.size() > 0) ? m_q.pop_front() : exp_t'(0);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        nReset = 1'b0;
        HostReq = 1'b0; LdReq = 1'b0; ClrReq = 1'b0; Lock = 1'b0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        nReset = 1'b1;
        #2;
        nReset = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 6'b0 || RegWrite !== '0 || RegData !== '0) begin
            n_fail++;
            $display("FAIL reset_async: flags=%b wr=%h data=%h, want 0/0/0", flags, RegWrite, RegData);
        end
        HostReq = 1'b1; LdReq = 1'b1; ClrReq = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b0 || RegWrite !== '0) begin
            n_fail++;
            $display("FAIL reset_held: flags=%b wr=%h, want 0/0", flags, RegWrite);
        end
        HostReq = 1'b0; LdReq = 1'b0; ClrReq = 1'b0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
    endtask

    task automatic test_host_write();
        int n_wr;
        do_reset();
        HostReq = 1'b1; HostAddr = 4'd3; HostData = 32'hDEADBEEF;
        @(posedge Clk);
        #1;
        HostData = 32'h12345678;
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b100010) begin
            n_fail++;
            $display("FAIL host_write_flags: got %b want 100010", flags);
        end
        n_cmp++;
        if (RegWrite !== 8'h08) begin
            n_fail++;
            $display("FAIL host_write_strobe: got %h want 08", RegWrite);
        end
        n_cmp++;
        if (RegData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL host_write_data: got %h want deadbeef", RegData);
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b0;
        n_wr = 0;
        repeat (4) begin
            @(negedge Clk);
            if (RegWrite !== '0 || HostAck !== 1'b0) n_wr++;
        end
        n_cmp++;
        if (n_wr !== 0) begin
            n_fail++;
            $display("FAIL host_write_single: extra write/ack cycles=%0d want 0", n_wr);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]          ef;
        logic [NUM_REGS-1:0] ew;
        do_reset();
        HostReq = 1'b1; HostAddr = 4'd1; HostData = 32'hAAAA0001;
        LdReq   = 1'b1; LdAddr   = 4'd2; LdData   = 32'hBBBB0002;
        @(posedge Clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (k % 2 == 1) begin
                ef = 6'b000000; ew = 8'h00;
            end else if (k % 4 == 0) begin
                ef = 6'b100010; ew = 8'h02;
            end else begin
                ef = 6'b010010; ew = 8'h04;
            end
            n_cmp++;
            if (flags !== ef || RegWrite !== ew) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: flags=%b wr=%h want %b/%h", k, flags, RegWrite, ef, ew);
            end
        end
        HostReq = 1'b0; LdReq = 1'b0;
    endtask

    task automatic test_addr_err();
        do_reset();
        LdReq = 1'b1; LdAddr = 4'd9; LdData = 32'hCAFE0009;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b011010 || RegWrite !== '0) begin
            n_fail++;
            $display("FAIL ld_addr9: flags=%b wr=%h want 011010/00", flags, RegWrite);
        end
        @(posedge Clk);
        #1;
        LdReq = 1'b0;
        HostReq = 1'b1; HostAddr = 4'd7; HostData = 32'h77777777;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b100010 || RegWrite !== 8'h80 || RegData !== 32'h77777777) begin
            n_fail++;
            $display("FAIL host_addr7: flags=%b wr=%h data=%h want 100010/80/77777777", flags, RegWrite, RegData);
        end
        @(posedge Clk);
        #1;
        HostAddr = 4'd8;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b101010 || RegWrite !== '0) begin
            n_fail++;
            $display("FAIL host_addr8: flags=%b wr=%h want 101010/00", flags, RegWrite);
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b0;
    endtask

    task automatic test_clear();
        logic [5:0]          ef[6];
        logic [NUM_REGS-1:0] ew[6];
        do_reset();
        ClrReq = 1'b1;
        @(posedge Clk);
        #1;
        ClrReq = 1'b0;
        ef[0] = 6'b000011; ef[1] = 6'b000110; ef[2] = 6'b000000;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (flags !== ef[k] || RegWrite !== '0) begin
                n_fail++;
                $display("FAIL clear_idle[%0d]: flags=%b wr=%h want %b/00", k, flags, RegWrite, ef[k]);
            end
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b1; HostAddr = 4'd5; HostData = 32'h55555555;
        @(posedge Clk);
        #1;
        ClrReq = 1'b1;
        HostAddr = 4'd6; HostData = 32'h66666666;
        ef[0] = 6'b100010; ew[0] = 8'h20;
        ef[1] = 6'b000000; ew[1] = 8'h00;
        ef[2] = 6'b000011; ew[2] = 8'h00;
        ef[3] = 6'b000110; ew[3] = 8'h00;
        ef[4] = 6'b000000; ew[4] = 8'h00;
        ef[5] = 6'b100010; ew[5] = 8'h40;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (flags !== ef[k] || RegWrite !== ew[k]) begin
                n_fail++;
                $display("FAIL clear_during_write[%0d]: flags=%b wr=%h want %b/%h", k, flags, RegWrite, ef[k], ew[k]);
            end
            if (k == 0) begin
                @(posedge Clk);
                #1;
                ClrReq = 1'b0;
            end
        end
        n_cmp++;
        if (RegData !== 32'h66666666) begin
            n_fail++;
            $display("FAIL clear_then_host_data: got %h want 66666666", RegData);
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
`ifdef ID_FILTER_REG_LOCK_EN
        begin
            int  n_h, n_l;
            bit  seen;
            logic [NUM_REGS-1:0] wr_at;
            n_h = 0; n_l = 0;
            Lock = 1'b1;
            HostReq = 1'b1; HostAddr = 4'd0; HostData = 32'h0000F00D;
            LdReq   = 1'b1; LdAddr   = 4'd4; LdData   = 32'h44444444;
            repeat (10) begin
                @(negedge Clk);
                if (HostAck === 1'b1) n_h++;
                if (LdAck === 1'b1) n_l++;
            end
            n_cmp++;
            if (n_h !== 0) begin
                n_fail++;
                $display("FAIL lock_host_blocked: host acks=%0d want 0", n_h);
            end
            n_cmp++;
            if (n_l !== 5) begin
                n_fail++;
                $display("FAIL lock_ld_served: ld acks=%0d want 5", n_l);
            end
            @(posedge Clk);
            #1;
            LdReq = 1'b0; Lock = 1'b0;
            seen = 1'b0; wr_at = '0;
            repeat (3) begin
                @(negedge Clk);
                if (!seen && HostAck === 1'b1) begin
                    seen = 1'b1; wr_at = RegWrite;
                end
            end
            n_cmp++;
            if (!seen || wr_at !== 8'h01) begin
                n_fail++;
                $display("FAIL lock_release_grant: seen=%0d wr=%h want 1/01", seen, wr_at);
            end
        end
`else
        Lock = 1'b1;
        HostReq = 1'b1; HostAddr = 4'd0; HostData = 32'h0000F00D;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b100010 || RegWrite !== 8'h01) begin
            n_fail++;
            $display("FAIL lock_ignored: flags=%b wr=%h want 100010/01", flags, RegWrite);
        end
`endif
        @(posedge Clk);
        #1;
        HostReq = 1'b0; LdReq = 1'b0; Lock = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        HostReq = 1'b1; HostAddr = 4'd2; HostData = 32'h22222222;
        @(posedge Clk);
        #1;
        n_cmp++;
        if (flags !== 6'b100010) begin
            n_fail++;
            $display("FAIL reset_mid_pre: flags=%b want 100010", flags);
        end
        #1;
        nReset = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 6'b0 || RegWrite !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: flags=%b wr=%h want 0/00", flags, RegWrite);
        end
        HostReq = 1'b0;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: flags=%b want 0", flags);
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b1; HostAddr = 4'd1; HostData = 32'h11111111;
        LdReq   = 1'b1; LdAddr   = 4'd2; LdData   = 32'h22220000;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (flags !== 6'b100010 || RegWrite !== 8'h02) begin
            n_fail++;
            $display("FAIL reset_mid_ptr_host: flags=%b wr=%h want 100010/02", flags, RegWrite);
        end
        @(posedge Clk);
        #1;
        HostReq = 1'b0; LdReq = 1'b0;
        @(posedge Clk);
    endtask

    task automatic test_random();
        logic [5:0] ef;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge Clk);
            model_step();
            #1;
            if (!nReset) begin
                nReset = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                nReset = 1'b0;
                model_reset();
            end
            if (HostReq && HostAck) begin
                HostReq = ($urandom_range(0, 1) == 1);
                HostAddr = AW'($urandom_range(0, 11)); HostData = $urandom;
            end else if (!HostReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    HostReq = 1'b1; HostAddr = AW'($urandom_range(0, 11)); HostData = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                HostReq = 1'b0;
            end
            if (LdReq && LdAck) begin
                LdReq = ($urandom_range(0, 1) == 1);
                LdAddr = AW'($urandom_range(0, 11)); LdData = $urandom;
            end else if (!LdReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    LdReq = 1'b1; LdAddr = AW'($urandom_range(0, 11)); LdData = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                LdReq = 1'b0;
            end
            ClrReq = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) Lock = ~Lock;
            @(negedge Clk);
            ef = {m_cur.hack, m_cur.lack, m_cur.aerr, m_cur.done, m_cur.busy, m_cur.sync};
            n_cmp++;
            if (flags !== ef) begin
                n_fail++;
                $display("FAIL rand_flags cyc %0d: got %b want %b", cyc, flags, ef);
            end
            n_cmp++;
            if (RegWrite !== m_cur.wr) begin
                n_fail++;
                $display("FAIL rand_strobe cyc %0d: got %h want %h", cyc, RegWrite, m_cur.wr);
            end
            if (m_cur.dchk) begin
                n_cmp++;
                if (RegData !== m_cur.data) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got %h want %h", cyc, RegData, m_cur.data);
                end
            end
        end
        HostReq = 1'b0; LdReq = 1'b0; ClrReq = 1'b0; Lock = 1'b0;
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_back_to_back();
        test_addr_err();
        test_clear();
        test_lock();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
